pipe_stage_reg: RTL and testbench

- Parametrised, handshaked pipeline stage register; successor to the fixed EX/MEM latch.
- Carries a control bundle, two data words and a write-back address between any two CPU stages (ID/EX, EX/MEM, MEM/WB).
- Adds a valid/ready handshake, stall back-pressure, synchronous flush (bubble insertion) and an optional 2-entry skid buffer so ready_o can be registered.

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/pipe_entry_reg.sv | 38 +++
 rtl/pipe_stage_reg.sv | 149 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the handshaked pipeline stage register: control-bit
// positions, default payload widths and the occupancy state encoding.
package pipe_pkg;

  localparam int CTRL_MEMREAD  = 0;
  localparam int CTRL_MEMWRITE = 1;
  localparam int CTRL_MEMTOREG = 2;
  localparam int CTRL_REGWRITE = 3;

  localparam int DEF_CTRL_W = 4;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_state_t;

endpackage

// File: rtl/pipe_entry_reg.sv
// One payload register (ctrl + two data words + write-back address).
// clr_ctrl wins over load so a bubble can never carry stale control bits.
module pipe_entry_reg #(
  parameter int CTRL_W = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clr_ctrl,
  input  logic [CTRL_W-1:0] ctrl_d,
  input  logic [DATA_W-1:0] data_a_d,
  input  logic [DATA_W-1:0] data_b_d,
  input  logic [ADDR_W-1:0] wb_addr_d,
  output logic [CTRL_W-1:0] ctrl_q,
  output logic [DATA_W-1:0] data_a_q,
  output logic [DATA_W-1:0] data_b_q,
  output logic [ADDR_W-1:0] wb_addr_q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q    <= '0;
      data_a_q  <= '0;
      data_b_q  <= '0;
      wb_addr_q <= '0;
    end else if (clr_ctrl) begin
      ctrl_q <= '0;
    end else if (load) begin
      ctrl_q    <= ctrl_d;
      data_a_q  <= data_a_d;
      data_b_q  <= data_b_d;
      wb_addr_q <= wb_addr_d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with flush and optional 2-entry skid
// buffer (SKID=1) that makes ready_o a registered signal.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int SKID   = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              flush_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] dataA_i,
  input  logic [DATA_W-1:0] dataB_i,
  input  logic [ADDR_W-1:0] wbAddr_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] dataA_o,
  output logic [DATA_W-1:0] dataB_o,
  output logic [ADDR_W-1:0] wbAddr_o,
  output logic [1:0]        occ_o
);

  logic              main_load;
  logic              main_clr;
  logic [CTRL_W-1:0] main_ctrl_d;
  logic [DATA_W-1:0] main_a_d;
  logic [DATA_W-1:0] main_b_d;
  logic [ADDR_W-1:0] main_addr_d;

  pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_main (
    .clk(clk_i), .rst_n(rst_i), .load(main_load), .clr_ctrl(main_clr),
    .ctrl_d(main_ctrl_d), .data_a_d(main_a_d), .data_b_d(main_b_d), .wb_addr_d(main_addr_d),
    .ctrl_q(ctrl_o), .data_a_q(dataA_o), .data_b_q(dataB_o), .wb_addr_q(wbAddr_o)
  );

  generate
    if (SKID == 0) begin : g_single
      logic valid_reg;
      logic accept;
      logic emit;

      assign ready_o     = ready_i | ~valid_reg;
      assign accept      = valid_i & ready_o;
      assign emit        = valid_reg & ready_i;
      assign main_load   = accept & ~flush_i;
      assign main_clr    = flush_i | (emit & ~accept);
      assign main_ctrl_d = ctrl_i;
      assign main_a_d    = dataA_i;
      assign main_b_d    = dataB_i;
      assign main_addr_d = wbAddr_i;
      assign valid_o     = valid_reg;
      assign occ_o       = {1'b0, valid_reg};

      always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)      valid_reg <= 1'b0;
        else if (flush_i) valid_reg <= 1'b0;
        else if (accept)  valid_reg <= 1'b1;
        else if (emit)    valid_reg <= 1'b0;
      end
    end else begin : g_skid
      occ_state_t        state_reg;
      occ_state_t        state_next;
      logic              ready_reg;
      logic              accept;
      logic              emit;
      logic              skid_load;
      logic              skid_clr;
      logic              from_skid;
      logic [CTRL_W-1:0] skid_ctrl;
      logic [DATA_W-1:0] skid_a;
      logic [DATA_W-1:0] skid_b;
      logic [ADDR_W-1:0] skid_addr;

      pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_skid (
        .clk(clk_i), .rst_n(rst_i), .load(skid_load), .clr_ctrl(skid_clr),
        .ctrl_d(ctrl_i), .data_a_d(dataA_i), .data_b_d(dataB_i), .wb_addr_d(wbAddr_i),
        .ctrl_q(skid_ctrl), .data_a_q(skid_a), .data_b_q(skid_b), .wb_addr_q(skid_addr)
      );

      assign ready_o = ready_reg;
      assign valid_o = (state_reg != EMPTY);
      assign occ_o   = state_reg;
      assign accept  = valid_i & ready_reg;
      assign emit    = valid_o & ready_i;

      // Main refills from the skid entry when draining TWO, keeping FIFO order.
      assign main_ctrl_d = from_skid ? skid_ctrl : ctrl_i;
      assign main_a_d    = from_skid ? skid_a    : dataA_i;
      assign main_b_d    = from_skid ? skid_b    : dataB_i;
      assign main_addr_d = from_skid ? skid_addr : wbAddr_i;

      always_comb begin
        state_next = state_reg;
        main_load  = 1'b0;
        main_clr   = 1'b0;
        skid_load  = 1'b0;
        skid_clr   = 1'b0;
        from_skid  = 1'b0;
        if (flush_i) begin
          state_next = EMPTY;
          main_clr   = 1'b1;
          skid_clr   = 1'b1;
        end else begin
          case (state_reg)
            EMPTY: if (accept) begin
              main_load  = 1'b1;
              state_next = ONE;
            end
            ONE: begin
              if (accept && !emit) begin
                skid_load  = 1'b1;
                state_next = TWO;
              end else if (accept && emit) begin
                main_load = 1'b1;
              end else if (emit) begin
                main_clr   = 1'b1;
                state_next = EMPTY;
              end
            end
            TWO: if (emit) begin
              main_load  = 1'b1;
              from_skid  = 1'b1;
              skid_clr   = 1'b1;
              state_next = ONE;
            end
            default: state_next = EMPTY;
          endcase
        end
      end

      always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
          state_reg <= EMPTY;
          ready_reg <= 1'b1;
        end else begin
          state_reg <= state_next;
          ready_reg <= (state_next != TWO);
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: one SKID=0 and one SKID=1 instance share the same stimulus;
// each scenario task checks the instance(s) whose behaviour it defines.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        ready_i = 1'b0;
  logic [3:0]  ctrl_i = '0;
  logic [31:0] dataA_i = '0;
  logic [31:0] dataB_i = '0;
  logic [4:0]  wbAddr_i = '0;

  logic        r0, v0, r1, v1;
  logic [3:0]  c0, c1;
  logic [31:0] a0, b0, a1, b1;
  logic [4:0]  w0, w1;
  logic [1:0]  o0, o1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.SKID(0)) u0 (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(r0), .flush_i(flush_i),
    .ctrl_i(ctrl_i), .dataA_i(dataA_i), .dataB_i(dataB_i), .wbAddr_i(wbAddr_i),
    .valid_o(v0), .ready_i(ready_i), .ctrl_o(c0), .dataA_o(a0), .dataB_o(b0),
    .wbAddr_o(w0), .occ_o(o0)
  );

  pipe_stage_reg #(.SKID(1)) u1 (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(r1), .flush_i(flush_i),
    .ctrl_i(ctrl_i), .dataA_i(dataA_i), .dataB_i(dataB_i), .wbAddr_i(wbAddr_i),
    .valid_o(v1), .ready_i(ready_i), .ctrl_o(c1), .dataA_o(a1), .dataB_o(b1),
    .wbAddr_o(w1), .occ_o(o1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] c, input logic [31:0] a, input logic [4:0] w);
    valid_i  = v;
    ctrl_i   = c;
    dataA_i  = a;
    wbAddr_i = w;
  endtask

  task automatic quiesce();
    drive(1'b0, 4'b0, 32'h0, 5'd0);
    flush_i = 1'b0;
    ready_i = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    drive(1'b0, 4'b0, 32'h0, 5'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({r0, v0, c0, a0, b0, w0, o0, r1, v1, c1, a1, b1, w1, o1} !==
          {1'b1, 1'b0, 4'b0, 32'h0, 32'h0, 5'd0, 2'd0, 1'b1, 1'b0, 4'b0, 32'h0, 32'h0, 5'd0, 2'd0}) begin
        failures++;
        $display("FAIL reset_state cycle=%0d got u0 r=%b v=%b c=%b a=%h o=%0d u1 r=%b v=%b c=%b a=%h o=%0d want r=1 v=0 c=0 a=0 o=0",
                 i, r0, v0, c0, a0, o0, r1, v1, c1, a1, o1);
      end
    end
    rst_i   = 1'b1;
    ready_i = 1'b1;
    dataB_i = 32'h55;
    drive(1'b1, 4'b1001, 32'h0000_00AA, 5'd7);
    tick();
    checks++;
    if ({v0, c0, a0, b0, w0, o0} !== {1'b1, 4'b1001, 32'hAA, 32'h55, 5'd7, 2'd1}) begin
      failures++;
      $display("FAIL first_push_u0 got v=%b c=%b a=%h b=%h w=%0d o=%0d want v=1 c=1001 a=aa b=55 w=7 o=1", v0, c0, a0, b0, w0, o0);
    end
    checks++;
    if ({v1, c1, a1, b1, w1, o1} !== {1'b1, 4'b1001, 32'hAA, 32'h55, 5'd7, 2'd1}) begin
      failures++;
      $display("FAIL first_push_u1 got v=%b c=%b a=%h b=%h w=%0d o=%0d want v=1 c=1001 a=aa b=55 w=7 o=1", v1, c1, a1, b1, w1, o1);
    end
    drive(1'b0, 4'b0, 32'h0, 5'd0);
    tick();
    checks++;
    if ({v0, c0, o0, v1, c1, o1} !== {1'b0, 4'b0, 2'd0, 1'b0, 4'b0, 2'd0}) begin
      failures++;
      $display("FAIL drain_after_push got u0 v=%b c=%b o=%0d u1 v=%b c=%b o=%0d want all 0", v0, c0, o0, v1, c1, o1);
    end
  endtask

  task automatic test_back_to_back();
    quiesce();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 4'b0001, 32'(i), 5'(i));
      #1;
      checks++;
      if ({r0, r1} !== 2'b11) begin
        failures++;
        $display("FAIL stream_ready i=%0d got r0=%b r1=%b want 1 1", i, r0, r1);
      end
      tick();
      checks++;
      if ({v0, a0, w0, v1, a1, w1, o1} !== {1'b1, 32'(i), 5'(i), 1'b1, 32'(i), 5'(i), 2'd1}) begin
        failures++;
        $display("FAIL stream_data i=%0d got u0 v=%b a=%h u1 v=%b a=%h o=%0d want v=1 a=%h o=1", i, v0, a0, v1, a1, o1, i);
      end
    end
    drive(1'b0, 4'b0, 32'h0, 5'd0);
    tick();
    checks++;
    if ({v0, v1, o1} !== {1'b0, 1'b0, 2'd0}) begin
      failures++;
      $display("FAIL stream_drain got v0=%b v1=%b o1=%0d want 0 0 0", v0, v1, o1);
    end
  endtask

  task automatic test_stall();
    quiesce();
    ready_i = 1'b0;
    drive(1'b1, 4'b1000, 32'h10, 5'd1);
    tick();
    checks++;
    if ({v1, a1, o1, r1} !== {1'b1, 32'h10, 2'd1, 1'b1}) begin
      failures++;
      $display("FAIL stall_one got v=%b a=%h o=%0d r=%b want v=1 a=10 o=1 r=1", v1, a1, o1, r1);
    end
    drive(1'b1, 4'b0100, 32'h20, 5'd2);
    tick();
    drive(1'b0, 4'b0, 32'h0, 5'd0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({v1, c1, a1, w1, o1, r1} !== {1'b1, 4'b1000, 32'h10, 5'd1, 2'd2, 1'b0}) begin
        failures++;
        $display("FAIL stall_hold cycle=%0d got v=%b c=%b a=%h w=%0d o=%0d r=%b want v=1 c=1000 a=10 w=1 o=2 r=0",
                 i, v1, c1, a1, w1, o1, r1);
      end
      if (i < 3) tick();
    end
    ready_i = 1'b1;
    tick();
    checks++;
    if ({v1, c1, a1, w1, o1} !== {1'b1, 4'b0100, 32'h20, 5'd2, 2'd1}) begin
      failures++;
      $display("FAIL stall_release1 got v=%b c=%b a=%h w=%0d o=%0d want v=1 c=0100 a=20 w=2 o=1", v1, c1, a1, w1, o1);
    end
    tick();
    checks++;
    if ({v1, c1, o1, r1} !== {1'b0, 4'b0, 2'd0, 1'b1}) begin
      failures++;
      $display("FAIL stall_release2 got v=%b c=%b o=%0d r=%b want v=0 c=0 o=0 r=1", v1, c1, o1, r1);
    end
  endtask

  task automatic test_flush();
    quiesce();
    ready_i = 1'b0;
    drive(1'b1, 4'b1001, 32'h30, 5'd3);
    tick();
    drive(1'b1, 4'b1001, 32'h40, 5'd4);
    tick();
    checks++;
    if ({o1, o0} !== {2'd2, 2'd1}) begin
      failures++;
      $display("FAIL flush_setup got o1=%0d o0=%0d want 2 1", o1, o0);
    end
    flush_i = 1'b1;
    drive(1'b1, 4'b0010, 32'h50, 5'd5);
    tick();
    flush_i = 1'b0;
    drive(1'b0, 4'b0, 32'h0, 5'd0);
    checks++;
    if ({v1, c1, o1, r1, v0, c0, o0} !== {1'b0, 4'b0, 2'd0, 1'b1, 1'b0, 4'b0, 2'd0}) begin
      failures++;
      $display("FAIL flush_state got u1 v=%b c=%b o=%0d r=%b u0 v=%b c=%b o=%0d want v=0 c=0 o=0 r=1",
               v1, c1, o1, r1, v0, c0, o0);
    end
    ready_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({v1, c1, v0, c0} !== {1'b0, 4'b0, 1'b0, 4'b0}) begin
        failures++;
        $display("FAIL flush_no_leak cycle=%0d got u1 v=%b c=%b a=%h u0 v=%b c=%b a=%h want v=0 c=0", i, v1, c1, a1, v0, c0, a0);
      end
    end
  endtask

  task automatic test_bubble();
    quiesce();
    drive(1'b1, 4'b1111, 32'h60, 5'd6);
    tick();
    checks++;
    if ({v0, c0, v1, c1} !== {1'b1, 4'b1111, 1'b1, 4'b1111}) begin
      failures++;
      $display("FAIL bubble_load got u0 v=%b c=%b u1 v=%b c=%b want v=1 c=1111", v0, c0, v1, c1);
    end
    drive(1'b0, 4'b1111, 32'h61, 5'd6);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({v0, c0, v1, c1} !== {1'b0, 4'b0, 1'b0, 4'b0}) begin
        failures++;
        $display("FAIL bubble_ctrl cycle=%0d got u0 v=%b c=%b u1 v=%b c=%b want v=0 c=0000", i, v0, c0, v1, c1);
      end
    end
  endtask

  task automatic test_async_reset();
    quiesce();
    ready_i = 1'b0;
    drive(1'b1, 4'b1001, 32'h70, 5'd9);
    tick();
    drive(1'b1, 4'b1001, 32'h80, 5'd10);
    tick();
    drive(1'b0, 4'b0, 32'h0, 5'd0);
    checks++;
    if (o1 !== 2'd2) begin
      failures++;
      $display("FAIL areset_setup got o1=%0d want 2", o1);
    end
    #2;
    rst_i = 1'b0;
    #1;
    checks++;
    if ({r0, v0, c0, a0, w0, o0, r1, v1, c1, a1, w1, o1} !==
        {1'b1, 1'b0, 4'b0, 32'h0, 5'd0, 2'd0, 1'b1, 1'b0, 4'b0, 32'h0, 5'd0, 2'd0}) begin
      failures++;
      $display("FAIL areset_immediate got u0 r=%b v=%b c=%b a=%h o=%0d u1 r=%b v=%b c=%b a=%h o=%0d want r=1 rest 0",
               r0, v0, c0, a0, o0, r1, v1, c1, a1, o1);
    end
    tick();
    rst_i   = 1'b1;
    ready_i = 1'b1;
    drive(1'b1, 4'b1001, 32'h0000_00AA, 5'd7);
    tick();
    drive(1'b0, 4'b0, 32'h0, 5'd0);
    checks++;
    if ({v0, c0, a0, w0, o0, v1, c1, a1, w1, o1} !==
        {1'b1, 4'b1001, 32'hAA, 5'd7, 2'd1, 1'b1, 4'b1001, 32'hAA, 5'd7, 2'd1}) begin
      failures++;
      $display("FAIL areset_repush got u0 v=%b c=%b a=%h o=%0d u1 v=%b c=%b a=%h o=%0d want v=1 c=1001 a=aa o=1",
               v0, c0, a0, o0, v1, c1, a1, o1);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_flush();
    test_bubble();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
